// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and width for the execute-stage multiply/divide unit
package muldiv_pkg;

  localparam int MULDIV_N = 64;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULH = 2'b01,
    OP_UDIV  = 2'b10,
    OP_SDIV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Both division flavours share the restoring datapath and the divide-by-zero bypass.
  function automatic logic is_div(op_e op_sel);
    return (op_sel == OP_UDIV) || (op_sel == OP_SDIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add (multiply) or shift-subtract (divide) iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int N = MULDIV_N
) (
  input  logic           i_div,
  input  logic [2*N-1:0] i_acc,
  input  logic [N-1:0]   i_opnd,
  output logic [2*N-1:0] o_acc
);

  logic [N:0] w_sum;
  logic [N:0] w_rem;
  logic [N:0] w_diff;

  // Multiply: acc = {partial product, remaining multiplier bits}, add on LSB then shift right.
  // Divide:   acc = {partial remainder, remaining dividend/quotient bits}, shift left then trial-subtract.
  always_comb begin
    w_sum  = {1'b0, i_acc[2*N-1:N]} + (i_acc[0] ? {1'b0, i_opnd} : {(N+1){1'b0}});
    w_rem  = {i_acc[2*N-1:N], i_acc[N-1]};
    w_diff = w_rem - {1'b0, i_opnd};
    if (!i_div) begin
      o_acc = {w_sum, i_acc[N-1:1]};
    end else if (w_rem >= {1'b0, i_opnd}) begin
      o_acc = {w_diff[N-1:0], i_acc[N-2:0], 1'b1};
    end else begin
      o_acc = {w_rem[N-1:0], i_acc[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/exec_muldiv.sv
// rtl/exec_muldiv.sv - iterative multiply/divide unit beside the execute-stage ALU
module exec_muldiv
  import muldiv_pkg::*;
#(
  parameter int N = MULDIV_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         zero
);

  localparam int CW = $clog2(N);

  state_e         r_state;
  state_e         w_next_state;
  logic [CW-1:0]  r_cnt;
  op_e            r_op;
  logic [N-1:0]   r_opnd;
  logic [2*N-1:0] r_acc;
  logic           r_neg;
  logic [N-1:0]   r_result;

  op_e            w_op;
  logic           w_accept;
  logic           w_sdiv;
  logic           w_div0;
  logic [N-1:0]   w_abs_a;
  logic [N-1:0]   w_abs_b;
  logic [2*N-1:0] w_step_acc;
  logic [N-1:0]   w_quot;
  logic [N-1:0]   w_final;

  assign w_op     = op_e'(op);
  assign w_accept = start && (r_state != S_RUN);
  assign w_sdiv   = (w_op == OP_SDIV);
  assign w_div0   = is_div(w_op) && (b == '0);
  // SDIV works on magnitudes; the most negative value maps onto itself, which is its correct unsigned magnitude.
  assign w_abs_a  = (w_sdiv && a[N-1]) ? -a : a;
  assign w_abs_b  = (w_sdiv && b[N-1]) ? -b : b;

  muldiv_step #(.N(N)) u_step (
    .i_div  (is_div(r_op)),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_step_acc)
  );

  assign w_quot = w_step_acc[N-1:0];

  // Select the value written to the result register as RUN finishes, after the final iteration.
  always_comb begin
    w_final = '0;
    case (r_op)
      OP_MUL:   w_final = w_step_acc[N-1:0];
      OP_UMULH: w_final = w_step_acc[2*N-1:N];
      OP_UDIV:  w_final = w_quot;
      OP_SDIV:  w_final = r_neg ? -w_quot : w_quot;
      default:  w_final = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: divide-by-zero bypasses RUN; a start in DONE chains straight into a new operation.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next_state = w_div0 ? S_DONE : S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == '0) begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // Datapath: latch operands on an accepted start, iterate in RUN, load result only when entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_op     <= OP_MUL;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op   <= w_op;
      r_cnt  <= CW'(N - 1);
      r_opnd <= w_abs_b;
      r_acc  <= {{N{1'b0}}, w_abs_a};
      r_neg  <= w_sdiv && (a[N-1] ^ b[N-1]);
      if (w_div0) begin
        r_result <= '0;
      end
    end else if (r_state == S_RUN) begin
      r_acc <= w_step_acc;
      if (r_cnt == '0) begin
        r_result <= w_final;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign result = r_result;
  assign zero   = (r_result == '0);

endmodule

// File: tb/tb_exec_muldiv.sv
// tb/tb_exec_muldiv.sv - scoreboard bench for exec_muldiv against an arithmetic reference model
module tb_exec_muldiv;

  localparam int N = 64;
  localparam logic [N-1:0] MIN_S = 64'h8000_0000_0000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         zero;

  exec_muldiv #(.N(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] res;
    int           cyc;
    string        tag;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  function automatic logic [N-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    logic [2*N-1:0] p;
    longint sx, sy;
    p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
    case (o)
      2'd0: return p[N-1:0];
      2'd1: return p[2*N-1:N];
      2'd2: return (y == 0) ? '0 : x / y;
      default: begin
        if (y == 0) return '0;
        if (x == MIN_S && y == '1) return MIN_S;
        sx = x;
        sy = y;
        return sx / sy;
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", N'(done), '0);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.tag, "_result"}, result, mon_e.res);
        chk({mon_e.tag, "_zero"}, N'(zero), N'(mon_e.res == '0));
        chk({mon_e.tag, "_cycle"}, N'(cyc), N'(mon_e.cyc));
      end
    end
  end

  // Issue one operation in the current cycle, scramble inputs after the latch, check busy each cycle.
  task automatic run_op(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic [N-1:0] exp_r, input string tag, input bit chain, input int poke);
    bit   d0;
    int   lat;
    exp_t e;
    d0    = (o >= 2'd2) && (y == '0);
    lat   = d0 ? 1 : N + 1;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    e.res = exp_r;
    e.cyc = cyc + lat;
    e.tag = tag;
    sbq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a     = rnd64();
    b     = rnd64();
    op    = 2'($urandom);
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk);
      chk({tag, "_busy"}, N'(busy), N'(j < lat));
      if (j == poke) begin
        start = 1'b1;
        a     = rnd64();
        b     = rnd64();
        op    = 2'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    if (!chain) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [1:0]   o;
    logic [N-1:0] x, y;
    bit           ch;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'd0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", N'(busy), '0);
    chk("reset_done", N'(done), '0);
    chk("reset_result", result, '0);
    chk("reset_zero", N'(zero), 1);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op(2'd0, 3, 5, 15, "mul_3x5", 0, 0);
    run_op(2'd1, MIN_S, 4, 2, "umulh", 0, 0);
    run_op(2'd0, MIN_S, 4, 0, "mul_wrap", 0, 0);
    run_op(2'd2, 100, 7, 14, "udiv", 0, 0);
    run_op(2'd3, 64'hFFFF_FFFF_FFFF_FF9C, 7, 64'hFFFF_FFFF_FFFF_FFF2, "sdiv_neg", 0, 0);
    run_op(2'd3, MIN_S, '1, MIN_S, "sdiv_ovf", 0, 0);
    run_op(2'd2, 42, 0, 0, "udiv_by0", 0, 0);
    run_op(2'd0, 64'd123456789, 64'd987654321, 64'd121932631112635269, "mul_poke", 0, 10);
    run_op(2'd2, 1000, 10, 100, "chain_a", 1, 0);
    run_op(2'd3, 7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, "chain_b", 1, 0);
    run_op(2'd3, 5, 0, 0, "chain_div0", 0, 0);

    // Reset wins over a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    op    = 2'd0;
    a     = 3;
    b     = 5;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_prio_busy", N'(busy), '0);
    chk("rst_prio_done", N'(done), '0);
    @(posedge clk); #1;

    // Abort a divide mid-RUN, then restart ten cycles later.
    k     = cyc;
    op    = 2'd2;
    a     = 64'd9999;
    b     = 64'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < k + 30) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", N'(busy), '0);
    chk("abort_done", N'(done), '0);
    chk("abort_zero", N'(zero), 1);
    while (cyc < k + 40) begin
      @(posedge clk); #1;
    end
    run_op(2'd2, 500, 7, 71, "udiv_after_reset", 0, 0);

    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom);
      x = rnd64();
      y = rnd64();
      case ($urandom % 6)
        0: y = 64'($urandom_range(0, 15));
        1: y = '0;
        2: x = MIN_S;
        3: y = '1;
        default: ;
      endcase
      ch = ($urandom % 3) == 0;
      run_op(o, x, y, model(o, x, y), $sformatf("rnd%0d_op%0d", i, o), ch, 0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", N'(sbq.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
